// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory window responder
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [15:0] DMEM_BASE  = 16'h0500;
  localparam logic [15:0] DMEM_LAST  = 16'h08FF;
  localparam int          WORD_W     = 32;
  localparam int          OFFSET_W   = 10;
  localparam int          DMEM_WORDS = int'(DMEM_LAST - DMEM_BASE) + 1;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - 1024x32 single-port storage, synchronous write, registered read
// Optional DMEM_BYTE_EN adds per-byte write lanes.
module dmem_array
  import dmem_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic                re,
  input  logic [OFFSET_W-1:0] addr,
  input  logic [WORD_W-1:0]   wdata,
`ifdef DMEM_BYTE_EN
  input  logic [3:0]          be,
`endif
  output logic [WORD_W-1:0]   rdata
);

  logic [WORD_W-1:0] mem [DMEM_WORDS];

  // Storage contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) begin
`ifdef DMEM_BYTE_EN
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
`else
      mem[addr] <= wdata;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory window responder: request capture, wait states, Ready/Err pulses
// Optional DMEM_BYTE_EN adds the ByteEn input for partial-word writes.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = DMEM_BASE,
  parameter int          DEPTH       = DMEM_WORDS,
  parameter int          WAIT_STATES = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CS_n,
  input  logic [15:0]       Address,
  input  logic              RE,
  input  logic              WE,
  input  logic [WORD_W-1:0] DataIn,
`ifdef DMEM_BYTE_EN
  input  logic [3:0]        ByteEn,
`endif
  output logic [WORD_W-1:0] DataOut,
  output logic              Ready,
  output logic              Busy,
  output logic              Err
);

  localparam logic [3:0]  WS_INIT = 4'(WAIT_STATES);
  localparam logic [16:0] WIN_END = {1'b0, BASE_ADDR} + 17'(DEPTH);

  state_t              state, state_next;
  logic [3:0]          count, count_next;
  logic [OFFSET_W-1:0] cap_off;
  logic [WORD_W-1:0]   cap_data;
  logic                cap_write;

  logic                req, in_window, illegal, accept;
  logic                mem_en, use_live;
  logic [OFFSET_W-1:0] req_off, mem_off;
  logic [WORD_W-1:0]   mem_wdata;
  logic                mem_write, mem_we, mem_re;

  assign in_window = ({1'b0, Address} >= {1'b0, BASE_ADDR}) && ({1'b0, Address} < WIN_END);
  assign req       = (state == IDLE) && !CS_n && (RE || WE);
  assign illegal   = (RE && WE) || !in_window;
  assign accept    = req && !illegal;
  assign req_off   = OFFSET_W'(Address - BASE_ADDR);

  always_comb begin
    state_next = state;
    count_next = count;
    mem_en     = 1'b0;
    use_live   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          // With no wait states the access happens on the sampling edge itself,
          // so the storage is driven straight from the live request.
          if (WAIT_STATES == 0) begin
            state_next = RESP;
            mem_en     = 1'b1;
            use_live   = 1'b1;
          end else begin
            state_next = WAIT;
            count_next = WS_INIT;
          end
        end
      end
      WAIT: begin
        if (count <= 4'd1) begin
          state_next = RESP;
          count_next = 4'd0;
          mem_en     = 1'b1;
        end else begin
          count_next = count - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      count     <= 4'd0;
      cap_off   <= '0;
      cap_data  <= '0;
      cap_write <= 1'b0;
      Err       <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      Err   <= req && illegal;
      if (accept) begin
        cap_off   <= req_off;
        cap_data  <= DataIn;
        cap_write <= WE;
      end
    end
  end

  assign mem_off   = use_live ? req_off : cap_off;
  assign mem_wdata = use_live ? DataIn  : cap_data;
  assign mem_write = use_live ? WE      : cap_write;
  // Reset landing on the RESP-entry edge must suppress the access.
  assign mem_we    = mem_en && mem_write  && !RST;
  assign mem_re    = mem_en && !mem_write && !RST;

`ifdef DMEM_BYTE_EN
  logic [3:0] cap_be, mem_be;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cap_be <= 4'h0;
    end else if (accept) begin
      cap_be <= ByteEn;
    end
  end

  assign mem_be = use_live ? ByteEn : cap_be;
`endif

  dmem_array u_array (
    .clk   (CLK),
    .rst   (RST),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_off),
    .wdata (mem_wdata),
`ifdef DMEM_BYTE_EN
    .be    (mem_be),
`endif
    .rdata (DataOut)
  );

  assign Ready = (state == RESP);
  assign Busy  = (state != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - bench for data_mem_responder at WAIT_STATES 1, 3 and 0
// Build with DMEM_BYTE_EN defined to also cover byte-lane writes.
module tb_data_mem_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [2:0]  cs_n = 3'b111;
  logic [15:0] Address = 16'h0000;
  logic        RE = 1'b0;
  logic        WE = 1'b0;
  logic [31:0] DataIn = 32'h0;
  logic [3:0]  be = 4'hF;
  logic [31:0] dout [3];
  logic [2:0]  rdy, bsy, er;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 CLK = ~CLK;

  data_mem_responder #(.WAIT_STATES(1)) u_dut0 (
    .CLK(CLK), .RST(RST), .CS_n(cs_n[0]), .Address(Address), .RE(RE), .WE(WE), .DataIn(DataIn),
`ifdef DMEM_BYTE_EN
    .ByteEn(be),
`endif
    .DataOut(dout[0]), .Ready(rdy[0]), .Busy(bsy[0]), .Err(er[0]));

  data_mem_responder #(.WAIT_STATES(3)) u_dut1 (
    .CLK(CLK), .RST(RST), .CS_n(cs_n[1]), .Address(Address), .RE(RE), .WE(WE), .DataIn(DataIn),
`ifdef DMEM_BYTE_EN
    .ByteEn(be),
`endif
    .DataOut(dout[1]), .Ready(rdy[1]), .Busy(bsy[1]), .Err(er[1]));

  data_mem_responder #(.WAIT_STATES(0)) u_dut2 (
    .CLK(CLK), .RST(RST), .CS_n(cs_n[2]), .Address(Address), .RE(RE), .WE(WE), .DataIn(DataIn),
`ifdef DMEM_BYTE_EN
    .ByteEn(be),
`endif
    .DataOut(dout[2]), .Ready(rdy[2]), .Busy(bsy[2]), .Err(er[2]));

  // Reference model: word contents per instance, plus the last value read.
  logic [31:0] mmem [3][1024];
  bit          mval [3][1024];
  logic [31:0] last_rd [3];
  bit          last_ok [3];

  typedef struct {
    logic        csn;
    logic [15:0] a;
    logic        r;
    logic        w;
    logic [31:0] din;
    logic        exp_rdy;
    logic        exp_err;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t tbl [12];

  function automatic int ws_of(input int d);
    case (d)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic release_bus();
    cs_n = 3'b111;
    RE   = 1'b0;
    WE   = 1'b0;
  endtask

  task automatic model_apply(input int d, input logic csn, input logic [15:0] a, input logic r, input logic w,
                             input logic [31:0] din, input logic [3:0] b, output bit acc, output bit err);
    int off;
    acc = 0;
    err = 0;
    if (csn || !(r || w)) return;
    if ((r && w) || a < 16'h0500 || a > 16'h08FF) begin
      err = 1;
      return;
    end
    acc = 1;
    off = int'(a - 16'h0500);
    if (w) begin
      if (mval[d][off] || b == 4'hF) begin
        mmem[d][off] = merge(mmem[d][off], din, b);
        mval[d][off] = 1;
      end
    end else begin
      last_rd[d] = mmem[d][off];
      last_ok[d] = mval[d][off];
    end
  endtask

  // Drives one request at a falling edge and watches ws+2 cycles; the request
  // is held until Ready, or dropped at once if the responder did not go busy.
  task automatic access(input int d, input logic csn, input logic [15:0] a, input logic r, input logic w,
                        input logic [31:0] din, input logic [3:0] b,
                        output int rdy_cnt, output int rdy_cyc, output int err_cnt, output int err_cyc,
                        output int busy_cnt);
    int ws;
    ws = ws_of(d);
    cs_n[d] = csn; Address = a; RE = r; WE = w; DataIn = din; be = b;
    rdy_cnt = 0; rdy_cyc = 0; err_cnt = 0; err_cyc = 0; busy_cnt = 0;
    for (int k = 1; k <= ws + 2; k++) begin
      @(negedge CLK);
      if (rdy[d]) begin rdy_cnt++; if (rdy_cyc == 0) rdy_cyc = k; end
      if (er[d])  begin err_cnt++; if (err_cyc == 0) err_cyc = k; end
      if (bsy[d]) busy_cnt++;
      if (rdy[d] || !bsy[d]) release_bus();
    end
  endtask

  task automatic run_check(input int d, input logic csn, input logic [15:0] a, input logic r, input logic w,
                           input logic [31:0] din, input logic [3:0] b, input bit exp_rdy, input bit exp_err,
                           input bit dout_known, input logic [31:0] exp_dout, input string tag);
    int rc, ry, ec, ey, bc, lat;
    lat = ws_of(d) + 1;
    access(d, csn, a, r, w, din, b, rc, ry, ec, ey, bc);
    chk({tag, ".ready_cnt"}, rc, exp_rdy ? 1 : 0);
    chk({tag, ".ready_cyc"}, ry, exp_rdy ? lat : 0);
    chk({tag, ".err_cnt"},   ec, exp_err ? 1 : 0);
    chk({tag, ".err_cyc"},   ey, exp_err ? 1 : 0);
    chk({tag, ".busy_cyc"},  bc, exp_rdy ? lat : 0);
    if (dout_known) chk({tag, ".dout"}, dout[d], exp_dout);
  endtask

  initial begin
    bit acc, err;
    int cnt;
    logic [15:0] pool [8];
    logic [15:0] a;
    logic        csn, r, w;
    logic [31:0] din;
    logic [3:0]  b;
    int d, p;

    for (int i = 0; i < 3; i++) begin
      last_rd[i] = 32'h0;
      last_ok[i] = 1;
    end

    tbl[0]  = '{1'b0, 16'h0500, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h00000000};
    tbl[1]  = '{1'b0, 16'h0500, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 16'h08FF, 1'b0, 1'b1, 32'h12345678, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[3]  = '{1'b0, 16'h08FF, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'h12345678};
    tbl[4]  = '{1'b0, 16'h0900, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b1, 32'h12345678};
    tbl[5]  = '{1'b1, 16'h0600, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h12345678};
    tbl[6]  = '{1'b0, 16'h0700, 1'b0, 1'b1, 32'h0A0B0C0D, 1'b1, 1'b0, 32'h12345678};
    tbl[7]  = '{1'b0, 16'h0700, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h12345678};
    tbl[8]  = '{1'b0, 16'h0700, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'h0A0B0C0D};
    tbl[9]  = '{1'b0, 16'h04FF, 1'b0, 1'b1, 32'h11111111, 1'b0, 1'b1, 32'h0A0B0C0D};
    tbl[10] = '{1'b0, 16'h0500, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[11] = '{1'b0, 16'h0600, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'hDEADBEEF};

    pool = '{16'h0500, 16'h0501, 16'h0502, 16'h0600, 16'h0700, 16'h0777, 16'h08FE, 16'h08FF};

    // Power-on reset, then check the asynchronous reset values.
    #2 RST = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset%0d.dout", i),  dout[i], 32'h0);
      chk($sformatf("reset%0d.ready", i), 32'(rdy[i]), 32'h0);
      chk($sformatf("reset%0d.busy", i),  32'(bsy[i]), 32'h0);
      chk($sformatf("reset%0d.err", i),   32'(er[i]), 32'h0);
    end
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Directed vectors on the WAIT_STATES=1 instance.
    foreach (tbl[i]) begin
      model_apply(0, tbl[i].csn, tbl[i].a, tbl[i].r, tbl[i].w, tbl[i].din, 4'hF, acc, err);
      run_check(0, tbl[i].csn, tbl[i].a, tbl[i].r, tbl[i].w, tbl[i].din, 4'hF,
                tbl[i].exp_rdy, tbl[i].exp_err, 1'b1, tbl[i].exp_dout, $sformatf("tbl%0d", i));
    end

`ifdef DMEM_BYTE_EN
    model_apply(0, 1'b0, 16'h0550, 1'b0, 1'b1, 32'h11223344, 4'hF, acc, err);
    run_check(0, 1'b0, 16'h0550, 1'b0, 1'b1, 32'h11223344, 4'hF, 1, 0, 1, 32'hDEADBEEF, "be.full");
    model_apply(0, 1'b0, 16'h0550, 1'b0, 1'b1, 32'hAABBCCDD, 4'b0101, acc, err);
    run_check(0, 1'b0, 16'h0550, 1'b0, 1'b1, 32'hAABBCCDD, 4'b0101, 1, 0, 1, 32'hDEADBEEF, "be.0101");
    model_apply(0, 1'b0, 16'h0550, 1'b1, 1'b0, 32'h0, 4'h0, acc, err);
    run_check(0, 1'b0, 16'h0550, 1'b1, 1'b0, 32'h0, 4'h0, 1, 0, 1, 32'h11BB33DD, "be.read1");
    model_apply(0, 1'b0, 16'h0550, 1'b0, 1'b1, 32'hFFFFFFFF, 4'h0, acc, err);
    run_check(0, 1'b0, 16'h0550, 1'b0, 1'b1, 32'hFFFFFFFF, 4'h0, 1, 0, 1, 32'h11BB33DD, "be.none");
    model_apply(0, 1'b0, 16'h0550, 1'b1, 1'b0, 32'h0, 4'hF, acc, err);
    run_check(0, 1'b0, 16'h0550, 1'b1, 1'b0, 32'h0, 4'hF, 1, 0, 1, 32'h11BB33DD, "be.read2");
`endif

    // Reset in the second WAIT cycle of a WAIT_STATES=3 write aborts it.
    model_apply(1, 1'b0, 16'h0600, 1'b0, 1'b1, 32'h13572468, 4'hF, acc, err);
    run_check(1, 1'b0, 16'h0600, 1'b0, 1'b1, 32'h13572468, 4'hF, 1, 0, 1, 32'h0, "rst.pre_w");
    model_apply(1, 1'b0, 16'h0600, 1'b1, 1'b0, 32'h0, 4'hF, acc, err);
    run_check(1, 1'b0, 16'h0600, 1'b1, 1'b0, 32'h0, 4'hF, 1, 0, 1, 32'h13572468, "rst.pre_r");
    cs_n[1] = 1'b0; Address = 16'h0600; RE = 1'b0; WE = 1'b1; DataIn = 32'hCAFEF00D; be = 4'hF;
    @(negedge CLK);
    chk("rst.busy_before", 32'(bsy[1]), 32'h1);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("rst.busy",  32'(bsy[1]), 32'h0);
    chk("rst.ready", 32'(rdy[1]), 32'h0);
    chk("rst.err",   32'(er[1]),  32'h0);
    chk("rst.dout1", dout[1], 32'h0);
    chk("rst.dout0", dout[0], 32'h0);
    release_bus();
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) last_rd[i] = 32'h0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (rdy[1]) cnt++;
    end
    chk("rst.no_ready", cnt, 0);
    model_apply(1, 1'b0, 16'h0600, 1'b1, 1'b0, 32'h0, 4'hF, acc, err);
    run_check(1, 1'b0, 16'h0600, 1'b1, 1'b0, 32'h0, 4'hF, 1, 0, 1, 32'h13572468, "rst.post_r");

    // Randomized traffic across all three instances against the model.
    for (int n = 0; n < 300; n++) begin
      d   = $urandom_range(0, 2);
      p   = $urandom_range(0, 99);
      if (p < 80)      a = pool[$urandom_range(0, 7)];
      else if (p < 90) a = 16'h0400 + 16'($urandom_range(0, 255));
      else             a = 16'h0900 + 16'($urandom_range(0, 255));
      p   = $urandom_range(0, 19);
      r   = (p <= 8) || (p == 17) || (p == 18);
      w   = (p >= 9 && p <= 18);
      csn = ($urandom_range(0, 9) == 0);
      din = $urandom;
`ifdef DMEM_BYTE_EN
      b = 4'($urandom_range(0, 15));
`else
      b = 4'hF;
`endif
      model_apply(d, csn, a, r, w, din, b, acc, err);
      run_check(d, csn, a, r, w, din, b, acc, err, last_ok[d], last_rd[d], $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
